// File: rtl/gshare_update_scheduler_if.sv
// Bundle between the branch-resolution sources (EXE branch units, LSU) and the gshare update
// scheduler. master = sources plus predictor side, slave = scheduler.
interface gshare_update_scheduler_if #(
    parameter int unsigned BHSR_WIDTH  = 8,
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned UPD_Q_DEPTH = 4
);
    localparam int unsigned QCW = $clog2(UPD_Q_DEPTH) + 1;

    logic                  br0_valid;
    logic                  br0_miss;
    logic                  br0_taken;
    logic [BHSR_WIDTH-1:0] br0_bhsr;
    logic [PC_WIDTH-1:0]   br0_pc;
    logic                  br1_valid;
    logic                  br1_miss;
    logic                  br1_taken;
    logic [BHSR_WIDTH-1:0] br1_bhsr;
    logic [PC_WIDTH-1:0]   br1_pc;
    logic                  store_set_violation;
    logic                  branch_miss_first;
    logic [BHSR_WIDTH-1:0] lsu_bhsr;

    logic                  out_cond_valid;
    logic                  out_miss_prediction;
    logic                  out_taken;
    logic [BHSR_WIDTH-1:0] out_bhsr;
    logic [PC_WIDTH-1:0]   out_addr;
    logic                  out_ssv;
    logic                  out_bmf;
    logic [BHSR_WIDTH-1:0] out_lsu_bhsr;
    logic [QCW-1:0]        q_count;

    modport master (
        output br0_valid, br0_miss, br0_taken, br0_bhsr, br0_pc,
        output br1_valid, br1_miss, br1_taken, br1_bhsr, br1_pc,
        output store_set_violation, branch_miss_first, lsu_bhsr,
        input  out_cond_valid, out_miss_prediction, out_taken, out_bhsr, out_addr,
        input  out_ssv, out_bmf, out_lsu_bhsr, q_count
    );

    modport slave (
        input  br0_valid, br0_miss, br0_taken, br0_bhsr, br0_pc,
        input  br1_valid, br1_miss, br1_taken, br1_bhsr, br1_pc,
        input  store_set_violation, branch_miss_first, lsu_bhsr,
        output out_cond_valid, out_miss_prediction, out_taken, out_bhsr, out_addr,
        output out_ssv, out_bmf, out_lsu_bhsr, q_count
    );
endinterface

// File: rtl/gshare_update_scheduler.sv
// Serialises up to two resolved branches per cycle onto the single gshare update port.
// Mispredictions bypass a small in-order training queue. Optional counters: GSHARE_UPD_STATS_EN.
module gshare_update_scheduler #(
    parameter int unsigned BHSR_WIDTH  = 8,
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned UPD_Q_DEPTH = 4,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input logic                        clk,
    input logic                        rst,
    gshare_update_scheduler_if.slave   bus
`ifdef GSHARE_UPD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]       stat_enq_cnt,
    output logic [CNT_WIDTH-1:0]       stat_drop_cnt,
    output logic [CNT_WIDTH-1:0]       stat_bypass_cnt
`endif
);
    localparam int unsigned PTRW = $clog2(UPD_Q_DEPTH);
    localparam int unsigned QCW  = PTRW + 1;

    if (UPD_Q_DEPTH < 2 || (UPD_Q_DEPTH & (UPD_Q_DEPTH - 1)) != 0 || CNT_WIDTH < 1)
    begin : g_param_check
        $error("UPD_Q_DEPTH must be a power of 2 >= 2 and CNT_WIDTH >= 1");
    end

    typedef struct packed {
        logic                  taken;
        logic [BHSR_WIDTH-1:0] bhsr;
        logic [PC_WIDTH-1:0]   pc;
    } entry_t;

    entry_t            mem_q [UPD_Q_DEPTH];
    entry_t            mem_d [UPD_Q_DEPTH];
    logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [QCW-1:0]    count_q, count_d;

    logic              byp0, byp1, bypass;
    logic              el0, el1, push0, push1, pop;
    logic [QCW-1:0]    free;
    logic [PTRW-1:0]   wr1_ptr;
    entry_t            head;

    always_comb begin
        byp0   = bus.br0_valid & bus.br0_miss;
        byp1   = ~byp0 & bus.br1_valid & bus.br1_miss;
        bypass = byp0 | byp1;
        // br1 behind a mispredicted br0 is wrong-path and never trains
        el0    = bus.br0_valid & ~bus.br0_miss;
        el1    = bus.br1_valid & ~bus.br1_miss & ~byp0;
        free   = QCW'(UPD_Q_DEPTH) - count_q;
        if (free >= QCW'(2)) begin
            push0 = el0;
            push1 = el1;
        end else if (free == QCW'(1)) begin
            push0 = el0;
            push1 = el1 & ~el0;
        end else begin
            push0 = 1'b0;
            push1 = 1'b0;
        end
        pop     = ~bypass & (count_q != '0);
        head    = mem_q[rd_ptr_q];
        wr1_ptr = wr_ptr_q + PTRW'(push0);

        mem_d = mem_q;
        if (push0) mem_d[wr_ptr_q] = '{bus.br0_taken, bus.br0_bhsr, bus.br0_pc};
        if (push1) mem_d[wr1_ptr]  = '{bus.br1_taken, bus.br1_bhsr, bus.br1_pc};
        wr_ptr_d = wr1_ptr + PTRW'(push1);
        rd_ptr_d = rd_ptr_q + PTRW'(pop);
        count_d  = count_q + QCW'(push0) + QCW'(push1) - QCW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        bus.out_cond_valid      = 1'b0;
        bus.out_miss_prediction = 1'b0;
        bus.out_taken           = 1'b0;
        bus.out_bhsr            = '0;
        bus.out_addr            = '0;
        if (byp0) begin
            bus.out_cond_valid      = 1'b1;
            bus.out_miss_prediction = 1'b1;
            bus.out_taken           = bus.br0_taken;
            bus.out_bhsr            = bus.br0_bhsr;
            bus.out_addr            = bus.br0_pc;
        end else if (byp1) begin
            bus.out_cond_valid      = 1'b1;
            bus.out_miss_prediction = 1'b1;
            bus.out_taken           = bus.br1_taken;
            bus.out_bhsr            = bus.br1_bhsr;
            bus.out_addr            = bus.br1_pc;
        end else if (count_q != '0) begin
            bus.out_cond_valid = 1'b1;
            bus.out_taken      = head.taken;
            bus.out_bhsr       = head.bhsr;
            bus.out_addr       = head.pc;
        end
        bus.out_ssv      = bus.store_set_violation;
        bus.out_bmf      = bus.branch_miss_first;
        bus.out_lsu_bhsr = bus.lsu_bhsr;
        bus.q_count      = count_q;
    end

`ifdef GSHARE_UPD_STATS_EN
    logic [CNT_WIDTH-1:0] enq_cnt_q, enq_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_WIDTH-1:0] byp_cnt_q, byp_cnt_d;
    logic [1:0]           n_enq, n_drop;
    logic [CNT_WIDTH:0]   enq_sum, drop_sum, byp_sum;

    always_comb begin
        n_enq    = {1'b0, push0} + {1'b0, push1};
        n_drop   = ({1'b0, el0} + {1'b0, el1}) - n_enq;
        enq_sum  = {1'b0, enq_cnt_q} + (CNT_WIDTH + 1)'(n_enq);
        drop_sum = {1'b0, drop_cnt_q} + (CNT_WIDTH + 1)'(n_drop);
        byp_sum  = {1'b0, byp_cnt_q} + (CNT_WIDTH + 1)'(bypass);
        // saturate on carry-out
        enq_cnt_d  = enq_sum[CNT_WIDTH]  ? '1 : enq_sum[CNT_WIDTH-1:0];
        drop_cnt_d = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
        byp_cnt_d  = byp_sum[CNT_WIDTH]  ? '1 : byp_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enq_cnt_q  <= '0;
            drop_cnt_q <= '0;
            byp_cnt_q  <= '0;
        end else begin
            enq_cnt_q  <= enq_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            byp_cnt_q  <= byp_cnt_d;
        end
    end

    assign stat_enq_cnt    = enq_cnt_q;
    assign stat_drop_cnt   = drop_cnt_q;
    assign stat_bypass_cnt = byp_cnt_q;
`endif
endmodule

// File: tb/tb_gshare_update_scheduler.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a queue-based model; a monitor
// on the falling edge compares DUT outputs against the predictions in order.
module tb_gshare_update_scheduler;
    localparam int unsigned BW = 8;
    localparam int unsigned PW = 32;
    localparam int unsigned D  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gshare_update_scheduler_if #(.BHSR_WIDTH(BW), .PC_WIDTH(PW), .UPD_Q_DEPTH(D)) bus ();

`ifdef GSHARE_UPD_STATS_EN
    logic [15:0] s_enq, s_drop, s_byp;
    gshare_update_scheduler #(.BHSR_WIDTH(BW), .PC_WIDTH(PW), .UPD_Q_DEPTH(D), .CNT_WIDTH(16))
    dut (.clk(clk), .rst(rst), .bus(bus.slave),
         .stat_enq_cnt(s_enq), .stat_drop_cnt(s_drop), .stat_bypass_cnt(s_byp));
`else
    gshare_update_scheduler #(.BHSR_WIDTH(BW), .PC_WIDTH(PW), .UPD_Q_DEPTH(D), .CNT_WIDTH(16))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

    typedef struct {
        bit          rst;
        bit          v0, m0, t0;
        bit [BW-1:0] b0;
        bit [PW-1:0] pc0;
        bit          v1, m1, t1;
        bit [BW-1:0] b1;
        bit [PW-1:0] pc1;
        bit          ssv, bmf;
        bit [BW-1:0] lb;
    } stim_t;

    typedef struct {
        bit          taken;
        bit [BW-1:0] bhsr;
        bit [PW-1:0] pc;
    } upd_t;

    typedef struct {
        bit          chk;
        bit          valid, miss, taken;
        bit [BW-1:0] bhsr;
        bit [PW-1:0] addr;
        bit          ssv, bmf;
        bit [BW-1:0] lb;
        int          qc;
    } exp_t;

    upd_t model_q[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Predict this cycle's outputs, then advance the model to the post-edge state.
    task automatic apply(input stim_t s);
        exp_t e;
        upd_t cand[$];
        int   free;
        bit   bypass;
        @(posedge clk);
        #1;
        rst = s.rst;
        bus.br0_valid = s.v0; bus.br0_miss = s.m0; bus.br0_taken = s.t0;
        bus.br0_bhsr = s.b0; bus.br0_pc = s.pc0;
        bus.br1_valid = s.v1; bus.br1_miss = s.m1; bus.br1_taken = s.t1;
        bus.br1_bhsr = s.b1; bus.br1_pc = s.pc1;
        bus.store_set_violation = s.ssv; bus.branch_miss_first = s.bmf; bus.lsu_bhsr = s.lb;

        e = '{default: '0};
        e.chk = !s.rst;
        e.ssv = s.ssv; e.bmf = s.bmf; e.lb = s.lb;
        e.qc  = model_q.size();
        bypass = 1'b1;
        if (s.v0 && s.m0) begin
            e.valid = 1; e.miss = 1; e.taken = s.t0; e.bhsr = s.b0; e.addr = s.pc0;
        end else if (s.v1 && s.m1) begin
            e.valid = 1; e.miss = 1; e.taken = s.t1; e.bhsr = s.b1; e.addr = s.pc1;
        end else begin
            bypass = 1'b0;
            if (model_q.size() > 0) begin
                e.valid = 1; e.taken = model_q[0].taken;
                e.bhsr = model_q[0].bhsr; e.addr = model_q[0].pc;
            end
        end
        exp_q.push_back(e);

        if (s.rst) begin
            model_q.delete();
        end else begin
            free = D - model_q.size();
            if (s.v0 && !s.m0) cand.push_back('{s.t0, s.b0, s.pc0});
            if (s.v1 && !s.m1 && !(s.v0 && s.m0)) cand.push_back('{s.t1, s.b1, s.pc1});
            if (!bypass && model_q.size() > 0) void'(model_q.pop_front());
            foreach (cand[i]) if (i < free) model_q.push_back(cand[i]);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow at %0t: got 0 expected 1 entries", $time);
            end else begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    check("out_cond_valid", bus.out_cond_valid, e.valid);
                    check("out_miss_prediction", bus.out_miss_prediction, e.miss);
                    check("out_taken", bus.out_taken, e.taken);
                    check("out_bhsr", bus.out_bhsr, e.bhsr);
                    check("out_addr", bus.out_addr, e.addr);
                    check("out_ssv", bus.out_ssv, e.ssv);
                    check("out_bmf", bus.out_bmf, e.bmf);
                    check("out_lsu_bhsr", bus.out_lsu_bhsr, e.lb);
                    check("q_count", 64'(bus.q_count), 64'(e.qc));
                end
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        bus.br0_valid = 0; bus.br0_miss = 0; bus.br0_taken = 0; bus.br0_bhsr = '0;
        bus.br0_pc = '0; bus.br1_valid = 0; bus.br1_miss = 0; bus.br1_taken = 0;
        bus.br1_bhsr = '0; bus.br1_pc = '0; bus.store_set_violation = 0;
        bus.branch_miss_first = 0; bus.lsu_bhsr = '0;

        s = idle(); s.rst = 1;
        apply(s); apply(s);
        apply(idle());

        // single training update appears one cycle later
        s = idle(); s.v0 = 1; s.t0 = 1; s.pc0 = 32'h100; s.b0 = 8'h05;
        apply(s); apply(idle()); apply(idle());

        // dual update drains in program order
        s = idle(); s.v0 = 1; s.pc0 = 32'h10; s.v1 = 1; s.pc1 = 32'h20; s.b1 = 8'h01;
        apply(s); apply(idle()); apply(idle());

        // bypass with two queued entries: head held, wrong-path br1 discarded
        s = idle(); s.v0 = 1; s.pc0 = 32'h30; s.v1 = 1; s.pc1 = 32'h40;
        apply(s);
        s = idle(); s.v0 = 1; s.m0 = 1; s.t0 = 1; s.b0 = 8'h03; s.pc0 = 32'h50;
        s.v1 = 1; s.pc1 = 32'h60;
        apply(s);
        // br1 miss: br0 enqueued, br1 bypassed
        s = idle(); s.v0 = 1; s.pc0 = 32'h70; s.v1 = 1; s.m1 = 1; s.pc1 = 32'h80;
        apply(s);
        // LSU passthrough
        s = idle(); s.ssv = 1; s.lb = 8'h0A;
        apply(s);
        repeat (4) apply(idle());

        // saturate queue with repeated dual updates, then drain
        for (int k = 0; k < 4; k++) begin
            s = idle(); s.v0 = 1; s.pc0 = 32'h200 + 32'(k * 8); s.v1 = 1;
            s.pc1 = 32'h204 + 32'(k * 8); s.t1 = 1;
            apply(s);
        end
        repeat (5) apply(idle());

        // reset with entries queued: stale entries never emerge
        s = idle(); s.v0 = 1; s.pc0 = 32'h300; s.v1 = 1; s.pc1 = 32'h304;
        apply(s);
        s.pc0 = 32'h308; s.pc1 = 32'h30C;
        apply(s);
        s = idle(); s.rst = 1;
        apply(s);
        repeat (3) apply(idle());

        for (int n = 0; n < 600; n++) begin
            s = idle();
            if ($urandom_range(0, 59) == 0) begin
                s.rst = 1;
            end else begin
                s.v0  = ($urandom_range(0, 9) < 6);
                s.m0  = s.v0 && ($urandom_range(0, 9) == 0);
                s.t0  = 1'($urandom);
                s.b0  = 8'($urandom);
                s.pc0 = $urandom;
                s.v1  = ($urandom_range(0, 9) < 5);
                s.m1  = s.v1 && ($urandom_range(0, 9) == 0);
                s.t1  = 1'($urandom);
                s.b1  = 8'($urandom);
                s.pc1 = $urandom;
                s.ssv = 1'($urandom);
                s.bmf = 1'($urandom);
                s.lb  = 8'($urandom);
            end
            apply(s);
        end
        repeat (6) apply(idle());

        @(negedge clk);
        #1;
        done = 1'b1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
